// File: rtl/key_sw_ctrl_pkg.sv
// Shared constants for the key/switch controller: register window base, register
// offsets and the register-select decode used by the controller and the processor top.
package key_sw_ctrl_pkg;

  localparam logic [15:0] KSW_BASE_DEFAULT = 16'hFFF0;

  localparam logic [2:0] OFF_KDATA = 3'd0;
  localparam logic [2:0] OFF_SDATA = 3'd2;
  localparam logic [2:0] OFF_KEVT  = 3'd4;
  localparam logic [2:0] OFF_KMASK = 3'd6;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 10;

  typedef enum logic [1:0] {
    REG_KDATA = 2'd0,
    REG_SDATA = 2'd1,
    REG_KEVT  = 2'd2,
    REG_KMASK = 2'd3
  } reg_sel_e;

  // Byte address bit 0 is ignored, so only bits [2:1] pick the halfword register.
  function automatic reg_sel_e decode_reg(input logic [1:0] off_hi);
    case ({off_hi, 1'b0})
      OFF_KDATA: return REG_KDATA;
      OFF_SDATA: return REG_SDATA;
      OFF_KEVT:  return REG_KEVT;
      OFF_KMASK: return REG_KMASK;
      default:   return REG_KDATA;
    endcase
  endfunction

endpackage

// File: rtl/key_sw_ctrl_if.sv
// Processor data-memory port into the key/switch register window.
// Handshake: no valid/ready; a load is combinational on addr, a store commits on the
// rising clock edge while we=1, and sel flags that addr falls inside the window.
interface key_sw_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic [DBITS-1:0] rdata;
  logic             sel;

  modport master (output addr, output wdata, output we, input rdata, input sel);
  modport slave  (input addr, input wdata, input we, output rdata, output sel);
endinterface

// File: rtl/debounce_cell.sv
// One pushbutton: 2-flop synchronizer, per-key debounce counter and debounced bit.
// armed_o goes high once a genuinely sampled released level has been seen since reset.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o,
  output logic armed_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          armed_q;
  logic [1:0]    valid_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      armed_q <= 1'b0;
      valid_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      valid_q <= {valid_q[0], 1'b1};
      // sync2_q holds the reset constant until two edges after release; only a real
      // released level may arm event generation, so a press held across reset is ignored.
      if (valid_q[1] && sync2_q) begin
        armed_q <= 1'b1;
      end
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign deb_o   = deb_q;
  assign armed_o = armed_q;

endmodule

// File: rtl/key_sw_ctrl.sv
// Memory-mapped pushbutton/slide-switch controller: debounced key and switch state,
// sticky key-press events with write-1-to-clear, an event mask and a pending flag.
module key_sw_ctrl
  import key_sw_ctrl_pkg::*;
#(
  parameter int unsigned      DBITS           = 16,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] BASE            = DBITS'(KSW_BASE_DEFAULT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_KEYS-1:0]  key_i,
  input  logic [NUM_SW-1:0]    sw_i,
  key_sw_ctrl_if.slave         bus,
  output logic                 evt_pending_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] key_deb;
  logic [NUM_KEYS-1:0] key_armed;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (key_i[k]),
      .deb_o  (key_deb[k]),
      .armed_o(key_armed[k])
    );
  end

  // Switch group: one shared counter for the whole vector.
  logic [NUM_SW-1:0] sw_sync1_q, sw_sync2_q, sw_prev_q, sw_deb_q, sw_deb_d;
  logic [CW-1:0]     sw_cnt_q, sw_cnt_d, sw_run;

  always_comb begin
    sw_deb_d = sw_deb_q;
    sw_cnt_d = sw_cnt_q;
    // A change of the synchronized vector restarts the stability run at this edge.
    sw_run   = (sw_sync2_q != sw_prev_q) ? '0 : sw_cnt_q;
    if (sw_sync2_q == sw_deb_q) begin
      sw_cnt_d = '0;
    end else if (sw_run == CNT_LAST) begin
      sw_deb_d = sw_sync2_q;
      sw_cnt_d = '0;
    end else if (sw_run != CNT_MAX) begin
      sw_cnt_d = sw_run + CW'(1);
    end else begin
      sw_cnt_d = sw_run;
    end
  end

  // Register file decode.
  logic     sel;
  logic     wr_en;
  reg_sel_e reg_sel;

  assign sel     = (bus.addr[DBITS-1:3] == BASE[DBITS-1:3]);
  assign reg_sel = decode_reg(bus.addr[2:1]);
  assign wr_en   = bus.we && sel;

  logic [NUM_KEYS-1:0] key_deb_prev_q;
  logic [NUM_KEYS-1:0] kevt_q, kevt_d, kevt_set, kevt_clr;
  logic [NUM_KEYS-1:0] kmask_q, kmask_d;
  logic                evt_pending_q;

  always_comb begin
    kevt_set = key_deb_prev_q & ~key_deb & key_armed;
    kevt_clr = (wr_en && reg_sel == REG_KEVT) ? bus.wdata[NUM_KEYS-1:0] : '0;
    // Set is OR-ed in after the clear so a simultaneous press survives the clear.
    kevt_d   = (kevt_q & ~kevt_clr) | kevt_set;
    kmask_d  = (wr_en && reg_sel == REG_KMASK) ? bus.wdata[NUM_KEYS-1:0] : kmask_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_sync1_q     <= '0;
      sw_sync2_q     <= '0;
      sw_prev_q      <= '0;
      sw_deb_q       <= '0;
      sw_cnt_q       <= '0;
      key_deb_prev_q <= '1;
      kevt_q         <= '0;
      kmask_q        <= '0;
      evt_pending_q  <= 1'b0;
    end else begin
      sw_sync1_q     <= sw_i;
      sw_sync2_q     <= sw_sync1_q;
      sw_prev_q      <= sw_sync2_q;
      sw_deb_q       <= sw_deb_d;
      sw_cnt_q       <= sw_cnt_d;
      key_deb_prev_q <= key_deb;
      kevt_q         <= kevt_d;
      kmask_q        <= kmask_d;
      evt_pending_q  <= |(kevt_q & kmask_q);
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (sel) begin
      case (reg_sel)
        REG_KDATA: bus.rdata = DBITS'(key_deb);
        REG_SDATA: bus.rdata = DBITS'(sw_deb_q);
        REG_KEVT:  bus.rdata = DBITS'(kevt_q);
        REG_KMASK: bus.rdata = DBITS'(kmask_q);
        default:   bus.rdata = '0;
      endcase
    end
  end

  assign bus.sel       = sel;
  assign evt_pending_o = evt_pending_q;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[0], bus.wdata[DBITS-1:NUM_KEYS]};

endmodule

// File: tb/tb_key_sw_ctrl.sv
// Directed bench for key_sw_ctrl with DEBOUNCE_CYCLES=4: reset, debounce latency,
// glitch rejection, event set/clear races, address decode and reset mid-press.
module tb_key_sw_ctrl;

  localparam int DBITS = 16;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       key = 4'hF;
  logic [9:0]       sw = 10'h155;
  logic             evt_pending;

  key_sw_ctrl_if #(.DBITS(DBITS)) bus ();

  key_sw_ctrl #(
    .DBITS          (DBITS),
    .DEBOUNCE_CYCLES(DEB),
    .BASE           (16'hFFF0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_i        (key),
    .sw_i         (sw),
    .bus          (bus),
    .evt_pending_o(evt_pending)
  );

  // Clock / reset block
  always #10 clk = ~clk;

  // Scoreboard
  logic [DBITS-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic compare(input string tag, input logic [DBITS-1:0] obs);
    logic [DBITS-1:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, e);
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [DBITS-1:0] a, input logic [DBITS-1:0] exp, input string tag);
    bus.addr = a;
    bus.we   = 1'b0;
    exp_q.push_back(exp);
    #1;
    compare(tag, bus.rdata);
  endtask

  task automatic chk_sel(input logic [DBITS-1:0] a, input logic exp, input string tag);
    bus.addr = a;
    exp_q.push_back(DBITS'(exp));
    #1;
    compare(tag, DBITS'(bus.sel));
  endtask

  task automatic chk_pend(input logic exp, input string tag);
    exp_q.push_back(DBITS'(exp));
    compare(tag, DBITS'(evt_pending));
  endtask

  task automatic wr(input logic [DBITS-1:0] a, input logic [DBITS-1:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  initial begin
    bus.addr  = 16'hFFF0;
    bus.wdata = '0;
    bus.we    = 1'b0;

    // Reset state
    step(3);
    rd(16'hFFF0, 16'h000F, "rst_kdata");
    rd(16'hFFF2, 16'h0000, "rst_sdata");
    rd(16'hFFF4, 16'h0000, "rst_kevt");
    rd(16'hFFF6, 16'h0000, "rst_kmask");
    chk_pend(1'b0, "rst_pending");

    // Release; the next rising edge is edge 1
    rst_n = 1'b1;
    rd(16'hFFF0, 16'h000F, "rel_kdata");
    for (int k = 1; k <= 6; k++) begin
      step(1);
      rd(16'hFFF2, (k < 6) ? 16'h0000 : 16'h0155, "sdata_settle");
    end
    chk_sel(16'hFFF0, 1'b1, "sel_in_window");

    // KEY[1] press with KMASK=2
    wr(16'hFFF6, 16'h0002);
    key = 4'hD;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      rd(16'hFFF0, (k >= 6) ? 16'h000D : 16'h000F, "press_kdata");
      rd(16'hFFF4, (k >= 7) ? 16'h0002 : 16'h0000, "press_kevt");
      chk_pend(k >= 8, "press_pending");
    end
    key = 4'hF;
    step(8);
    rd(16'hFFF0, 16'h000F, "release_kdata");
    rd(16'hFFF4, 16'h0002, "release_kevt_sticky");
    wr(16'hFFF4, 16'h000F);
    rd(16'hFFF4, 16'h0000, "kevt_w1c_all");
    step(1);
    chk_pend(1'b0, "pending_cleared");

    // KEY[0] glitch of 3 cycles
    key = 4'hE;
    step(3);
    key = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      rd(16'hFFF0, 16'h000F, "glitch_kdata");
      rd(16'hFFF4, 16'h0000, "glitch_kevt");
    end

    // Switch change and switch glitch
    sw = 10'h2AA;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      rd(16'hFFF2, (k < 6) ? 16'h0155 : 16'h02AA, "sw_change");
    end
    sw = 10'h2AB;
    step(2);
    sw = 10'h2AA;
    step(8);
    rd(16'hFFF2, 16'h02AA, "sw_glitch");

    // KEVT=3, clear bit 0 only
    key = 4'hC;
    step(7);
    rd(16'hFFF4, 16'h0003, "kevt_both");
    wr(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0002, "kevt_clear_bit0");
    key = 4'hF;
    step(8);
    wr(16'hFFF4, 16'h0002);
    rd(16'hFFF4, 16'h0000, "kevt_clear_bit1");

    // Clear of bit 1 on the same edge that KEY[1] sets it: set wins
    key = 4'hD;
    step(6);
    rd(16'hFFF0, 16'h000D, "race_kdata");
    rd(16'hFFF4, 16'h0000, "race_kevt_before");
    wr(16'hFFF4, 16'h0002);
    rd(16'hFFF4, 16'h0002, "race_set_wins");

    // Address decode and read-only registers
    wr(16'hFFF0, 16'hFFFF);
    wr(16'hFFF2, 16'hFFFF);
    wr(16'hFFF8, 16'hFFFF);
    wr(16'hFFFE, 16'h000F);
    wr(16'hFFFC, 16'h000F);
    rd(16'hFFF0, 16'h000D, "ro_kdata");
    rd(16'hFFF2, 16'h02AA, "ro_sdata");
    rd(16'hFFF4, 16'h0002, "outside_kevt");
    rd(16'hFFF6, 16'h0002, "outside_kmask");
    rd(16'hFFF8, 16'h0000, "rdata_sel0");
    chk_sel(16'hFFF8, 1'b0, "sel_outside");
    chk_sel(16'hFFEF, 1'b0, "sel_below");
    rd(16'hFFF7, 16'h0002, "odd_addr_kmask");
    rd(16'hFFF1, 16'h000D, "odd_addr_kdata");
    wr(16'hFFF7, 16'hFFF5);
    rd(16'hFFF6, 16'h0005, "kmask_upper_zero");
    wr(16'hFFF6, 16'h0004);
    rd(16'hFFF6, 16'h0004, "kmask_write");

    // Reset pulsed at edge 4 of a KEY[2] press
    key = 4'hF;
    step(8);
    wr(16'hFFF4, 16'h000F);
    key = 4'hB;
    step(3);
    rst_n = 1'b0;
    #1;
    rd(16'hFFF0, 16'h000F, "midrst_kdata");
    rd(16'hFFF4, 16'h0000, "midrst_kevt");
    rd(16'hFFF6, 16'h0000, "midrst_kmask");
    chk_pend(1'b0, "midrst_pending");
    step(1);
    rst_n = 1'b1;
    wr(16'hFFF6, 16'h0004);
    step(10);
    rd(16'hFFF0, 16'h000B, "held_kdata");
    rd(16'hFFF4, 16'h0000, "held_no_event");
    chk_pend(1'b0, "held_no_pending");
    rd(16'hFFF2, 16'h02AA, "postrst_sdata");
    key = 4'hF;
    step(8);
    rd(16'hFFF0, 16'h000F, "rerelease_kdata");
    rd(16'hFFF4, 16'h0000, "rerelease_kevt");
    key = 4'hB;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      rd(16'hFFF4, (k >= 7) ? 16'h0004 : 16'h0000, "repress_kevt");
      chk_pend(k >= 8, "repress_pending");
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_sw_ctrl.md
KEY_SW_CTRL -- requirements
Module: key_sw_ctrl

Interface
REQ-001 Parameter DBITS, default 16, data/address width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable cycles needed to accept an input change (10 ms at 50 MHz).
REQ-003 Parameter BASE, default 16'hFFF0, base of the 8-byte register window.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 KEY  input  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-007 SW  input  10  raw slide switches, asynchronous.
REQ-008 ADDR  input  DBITS  data-memory byte address from the processor.
REQ-009 WDATA  input  DBITS  store data.
REQ-010 WE  input  1  store strobe; write occurs on the rising edge.
REQ-011 RDATA  output  DBITS  combinational load data.
REQ-012 SEL  output  1  combinational; 1 when ADDR[DBITS-1:3] == BASE[DBITS-1:3].
REQ-013 EVT_PENDING  output  1  registered; equals |(KEVT & KMASK).

Function
REQ-014 Register map (ADDR[0] ignored): +0 KDATA (read-only, [3:0] debounced keys, active-low preserved); +2 SDATA (read-only, [9:0] debounced switches); +4 KEVT (sticky press events [3:0], write-1-to-clear); +6 KMASK (read/write [3:0]).
REQ-015 Unused upper bits SHALL read 0; RDATA SHALL be 0 when SEL=0.
REQ-016 Writes to KDATA or SDATA, and writes with SEL=0, SHALL have no effect.
REQ-017 Each KEY and SW bit SHALL pass through a 2-flop synchronizer.
REQ-018 Each key SHALL have its own debounce counter: it increments on every edge at which the synchronized bit differs from the debounced bit, and clears on any edge where they match.
REQ-019 The debounced key bit SHALL take the synchronized value on the DEBOUNCE_CYCLES-th consecutive differing edge. The counter clears on that same edge.
REQ-020 Latency: an input held stable from before edge 1 changes the debounced value at edge DEBOUNCE_CYCLES+2.
REQ-021 The switches SHALL share one counter: any change in the synchronized SW vector clears it. The whole debounced SW vector updates after DEBOUNCE_CYCLES consecutive cycles with the synchronized vector stable and different from the debounced vector.
REQ-022 A debounced key transition 1->0 SHALL set the matching KEVT bit one edge after the debounced change.
REQ-023 A KEVT write of 1 SHALL clear that bit. A write of 0 SHALL leave it unchanged.
REQ-024 If a set and a clear hit the same bit on the same edge, the set wins.
REQ-025 A glitch shorter than DEBOUNCE_CYCLES SHALL change neither the debounced value nor KEVT.
REQ-026 EVT_PENDING SHALL update one edge after any change in KEVT or KMASK.
REQ-027 Counters SHALL saturate and never wrap. Counter width is clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-028 While RESET_N=0: KEY synchronizers and debounced KEY = 4'hF; SW synchronizers and debounced SW = 0; counters = 0; KEVT = 0; KMASK = 0; EVT_PENDING = 0.
REQ-029 Reset asserted mid-debounce SHALL abort the count. No event SHALL be generated for a press already in progress; it is recognised only after release and a new press.

Structure
REQ-030 A shared package SHALL hold the register offsets (KDATA=0, SDATA=2, KEVT=4, KMASK=6) and the BASE default. The processor top SHALL use the same constants for its address decode.
REQ-031 The per-key debounce logic SHALL be one sub-module, debounce_cell (synchronizer, counter, debounced bit), instantiated four times.
REQ-032 The switch group logic and the register file SHALL stay in key_sw_ctrl.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset release with KEY=4'hF, SW=10'h155 -> read FFF0=0x000F immediately; FFF2=0x0000 until edge 6, then 0x0155.
REQ-034 KEY[1] falls before edge 1 and is held -> KDATA=0x000D at edge 6, KEVT=0x0002 at edge 7; with KMASK=0x2, EVT_PENDING=1 at edge 8.
REQ-035 KEY[0] low for 3 cycles then high -> KDATA stays 0x000F; KEVT stays 0.
REQ-036 KEVT=0x0003, write FFF4=0x0001 -> KEVT=0x0002. A write of 0x0002 on the same edge that KEY[1] sets again -> KEVT bit 1 stays 1.
REQ-037 Write FFF0=0xFFFF and write FFF8 -> no register change; FFF8 read gives RDATA=0, SEL=0. Read FFF7 -> same data as FFF6.
REQ-038 RESET_N pulsed low at edge 4 of a KEY[2] press -> no KEVT. A new press after release sets KEVT bit 2.
